// File: rtl/mem_pack_pkg.sv
// mem_pack_pkg: shared types for the byte-write / word-read packing store
package mem_pack_pkg;
  localparam int LANES = 4;
  typedef logic [1:0] lane_t;
  typedef logic [9:0] word_t;
  typedef enum logic {EMPTY, PARTIAL} stage_e;
endpackage

// File: rtl/Gen1Kx8BRAM.sv
// Gen1Kx8BRAM: 1Kx8 block RAM, port A write-only, port B registered read with optional write
module Gen1Kx8BRAM (
  input  logic       iClk,
  input  logic       iWEA,
  input  logic [9:0] ivAddressA,
  input  logic [7:0] ivDataA,
  input  logic       iWEB,
  input  logic [9:0] ivAddressB,
  input  logic [7:0] ivDataB,
  output logic [7:0] ovDataB
);
  logic [7:0] mem [1024];
  always_ff @(posedge iClk) begin
    if (iWEA) mem[ivAddressA] <= ivDataA;
    if (iWEB) mem[ivAddressB] <= ivDataB;
    ovDataB <= mem[ivAddressB];
  end
endmodule

// File: rtl/mem_4kx8_to_1kx32_packer.sv
// mem_4kx8_to_1kx32_packer: byte writes staged into one word, committed to four lane RAMs, read 32-bit with forwarding
module mem_4kx8_to_1kx32_packer
  import mem_pack_pkg::*;
  #(parameter int unsigned TIMEOUT_CYCLES = 255)
(
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iWEB,
  input  logic [11:0] ivAddressB,
  input  logic [7:0]  ivDataB,
  input  logic        iFlush,
  input  logic        iRdReq,
  input  logic [9:0]  ivAddressA,
  output logic [31:0] ovDataA,
  output logic        oRdValid,
  output logic        oStaged,
  output logic        oCommit
);
  lane_t l;
  word_t a, sa, sa_n, ca;
  logic [3:0] sm, sm_n, cm, lm, fm;
  logic [31:0] sd, sd_n, cd, wd, fd, q, mx;
  logic fp, fp_n, ce, to, f, v1;
  stage_e st;
  assign l = ivAddressB[1:0];
  assign a = ivAddressB[11:2];
  assign st = sm == 4'b0 ? EMPTY : PARTIAL;
  assign lm = 4'b1 << l;
  assign f = iFlush || fp || to;
  assign oStaged = st == PARTIAL && !iRst;
  assign oCommit = ce;
`ifdef MEM_4KX8_1KX32_COMMIT_TIMEOUT_EN
  logic [15:0] cnt;
  assign to = !iWEB && st == PARTIAL && cnt == 16'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge iClk) cnt <= iRst || iWEB || st == EMPTY ? 16'd0 : cnt + 16'd1;
`else
  assign to = 1'b0;
`endif
  always_comb begin
    wd = sd;
    wd[{l, 3'b000} +: 8] = ivDataB;
    sa_n = sa;
    sm_n = sm;
    sd_n = sd;
    fp_n = 1'b0;
    ca = sa;
    cm = sm;
    cd = sd;
    ce = f && st == PARTIAL;
    if (iWEB && (st == EMPTY || sa == a)) begin
      ca = a;
      cm = (st == EMPTY ? 4'b0 : sm) | lm;
      cd = wd;
      ce = l == 2'd3 || f;
      sa_n = a;
      sd_n = wd;
      sm_n = ce ? 4'b0 : cm;
    end else if (iWEB) begin
      ce = 1'b1;
      sa_n = a;
      sd_n = wd;
      sm_n = lm;
      fp_n = l == 2'd3 || iFlush;
    end else if (ce) sm_n = 4'b0;
    if (iRst) ce = 1'b0;
  end
  always_comb begin
    mx = q;
    for (int i = 0; i < LANES; i++) if (fm[i]) mx[8*i +: 8] = fd[8*i +: 8];
  end
  always_ff @(posedge iClk) begin
    sa <= sa_n;
    sd <= sd_n;
    fd <= sd;
    fm <= sa == ivAddressA ? sm : 4'b0;
    if (iRst) begin
      sm <= 4'b0;
      fp <= 1'b0;
      v1 <= 1'b0;
      oRdValid <= 1'b0;
      ovDataA <= 32'b0;
    end else begin
      sm <= sm_n;
      fp <= fp_n;
      v1 <= iRdReq;
      oRdValid <= v1;
      if (v1) ovDataA <= mx;
    end
  end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    Gen1Kx8BRAM u_ram (
      .iClk(iClk),
      .iWEA(ce && cm[i]),
      .ivAddressA(ca),
      .ivDataA(cd[8*i +: 8]),
      .iWEB(1'b0),
      .ivAddressB(ivAddressA),
      .ivDataB(8'h00),
      .ovDataB(q[8*i +: 8])
    );
  end
endmodule

// File: tb/tb_mem_4kx8_to_1kx32_packer.sv
// tb_mem_4kx8_to_1kx32_packer: scoreboard bench against a byte-array model of write visibility
module tb_mem_4kx8_to_1kx32_packer;
  logic clk = 0, rst = 1, rst_q = 0, web = 0, flush = 0, rdreq = 0, last_commit = 0;
  logic [11:0] ab = 0;
  logic [7:0] db = 0, old;
  logic [9:0] aa = 0;
  logic [31:0] da;
  logic rv, staged, commit;
  int cyc = 0, pass = 0, total = 0, ncommit = 0, c0;
  logic [7:0] vis [4096];
  logic [31:0] qd [$];
  int qc [$];
  mem_4kx8_to_1kx32_packer #(.TIMEOUT_CYCLES(4)) dut (
    .iClk(clk), .iRst(rst), .iWEB(web), .ivAddressB(ab), .ivDataB(db), .iFlush(flush),
    .iRdReq(rdreq), .ivAddressA(aa), .ovDataA(da), .oRdValid(rv), .oStaged(staged), .oCommit(commit)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_q <= rst;
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h want %h", n, act, exp);
  endtask
  always @(negedge clk) begin
    if (rst_q) begin
      chk("rst_outputs", {28'b0, rv, staged, commit}, 32'b0);
      chk("rst_data", da, 32'b0);
    end else if (rv) begin
      if (qd.size() == 0) chk("spurious_valid", 32'd1, 32'd0);
      else begin
        chk("rd_data", da, qd.pop_front());
        chk("rd_latency", cyc, qc.pop_front() + 2);
      end
    end
  end
  task automatic step(input logic w, input logic [11:0] a, input logic [7:0] d, input logic f,
                      input logic r, input logic [9:0] ra);
    web = w; ab = a; db = d; flush = f; rdreq = r; aa = ra;
    if (r) begin
      qd.push_back({vis[{ra, 2'd3}], vis[{ra, 2'd2}], vis[{ra, 2'd1}], vis[{ra, 2'd0}]});
      qc.push_back(cyc);
    end
    if (w) vis[a] = d;
    @(negedge clk);
    last_commit = commit;
    if (commit) ncommit++;
    @(posedge clk);
    #1;
    web = 0; flush = 0; rdreq = 0;
  endtask
  task automatic idle(); step(0, 12'h0, 8'h0, 0, 0, 10'h0); endtask
  task automatic wr(input logic [11:0] a, input logic [7:0] d); step(1, a, d, 0, 0, 10'h0); endtask
  task automatic rd(input logic [9:0] ra); step(0, 12'h0, 8'h0, 0, 1, ra); endtask
  task automatic fl(); step(0, 12'h0, 8'h0, 1, 0, 10'h0); endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    chk("reset_staged", {31'b0, staged}, 32'd0);
    for (int i = 0; i < 4096; i++) wr(i[11:0], 8'($urandom));
    chk("fill_commits", ncommit, 32'd1024);
    chk("fill_staged", {31'b0, staged}, 32'd0);
    c0 = ncommit;
    wr(12'h010, 8'h11); wr(12'h011, 8'h22); wr(12'h012, 8'h33);
    chk("t1_no_early_commit", ncommit - c0, 32'd0);
    wr(12'h013, 8'h44);
    chk("t1_commit_on_lane3", {31'b0, last_commit}, 32'd1);
    chk("t1_commit_once", ncommit - c0, 32'd1);
    rd(10'h004); idle(); idle();
    c0 = ncommit;
    wr(12'h020, 8'hAA); wr(12'h021, 8'hBB);
    chk("t2_staged", {31'b0, staged}, 32'd1);
    wr(12'h030, 8'hCC);
    chk("t2_commit_on_change", ncommit - c0, 32'd1);
    chk("t2_still_staged", {31'b0, staged}, 32'd1);
    rd(10'h008); rd(10'h00C); idle(); idle(); fl();
    step(1, 12'h041, 8'h5A, 0, 1, 10'h010);
    rd(10'h010); idle(); idle(); fl(); idle();
    old = vis[12'h051];
    wr(12'h051, 8'hEE);
    chk("t4_staged", {31'b0, staged}, 32'd1);
    rst = 1; flush = 1;
    @(negedge clk);
    chk("t4_no_commit_in_reset", {31'b0, commit}, 32'd0);
    @(posedge clk);
    #1;
    flush = 0;
    @(posedge clk);
    #1;
    rst = 0;
    vis[12'h051] = old;
    chk("t4_staging_discarded", {31'b0, staged}, 32'd0);
    rd(10'h014); idle(); idle();
    for (int i = 0; i < 8; i++) step(1, {10'd3, 2'($urandom)}, 8'($urandom), 0, 1, i[9:0]);
    idle(); idle(); fl(); idle();
    c0 = ncommit;
    wr(12'h060, 8'h77);
`ifdef MEM_4KX8_1KX32_COMMIT_TIMEOUT_EN
    for (int i = 1; i <= 4; i++) begin
      idle();
      chk("t6_timeout_commit", {31'b0, last_commit}, {31'b0, i == 4});
    end
    chk("t6_staged_falls", {31'b0, staged}, 32'd0);
`else
    repeat (10) idle();
    chk("t6_no_timeout", ncommit - c0, 32'd0);
    chk("t6_still_staged", {31'b0, staged}, 32'd1);
    fl();
    chk("t6_flush_commits", {31'b0, last_commit}, 32'd1);
`endif
    rd(10'h018); idle(); idle();
    for (int i = 0; i < 2000; i++)
      step(1'($urandom), {7'b0, 3'($urandom), 2'($urandom)}, 8'($urandom), ($urandom % 8) == 0,
           1'($urandom), {7'b0, 3'($urandom)});
    repeat (4) idle();
    chk("sb_drained", qd.size(), 32'd0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
